// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared constants and sizing helper for the PDM decimation chain
//
// Purpose: default CIC geometry and the register-width rule, so downstream
//          half-band blocks can size their inputs from the same source.
// Contents:
//   CIC_N_STAGES  default number of integrator/comb stages
//   CIC_R_LOG2    default log2 of the CIC decimation ratio
//   cic_out_w()   Hogenauer width: 1 + N*log2(R) for differential delay 1
package pdm_pkg;

  localparam int CIC_N_STAGES = 4;
  localparam int CIC_R_LOG2   = 4;

  // Width that holds R**N exactly; integrators may wrap at this width
  // while the comb differences stay exact.
  function automatic int cic_out_w(input int n_stages, input int r_log2);
    return 1 + n_stages * r_log2;
  endfunction

endpackage

// File: rtl/decim_strobe_gen.sv
// rtl/decim_strobe_gen.sv - free-running decimation strobe generator
//
// Purpose: counts 0..2**R_LOG2-1 and flags the last count, giving a
//          one-cycle enable every 2**R_LOG2 clocks on a single clock domain.
// Ports:
//   clk     system clock
//   rst     synchronous, active-high reset (counter clears to 0)
//   strobe  high while the counter sits at its terminal count
module decim_strobe_gen #(
  parameter int R_LOG2 = 4
) (
  input  logic clk,
  input  logic rst,
  output logic strobe
);

  logic [R_LOG2-1:0] cnt;

  // Natural binary wrap at the terminal count, so the wrap and the strobe
  // fall on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign strobe = (cnt == {R_LOG2{1'b1}});

endmodule

// File: rtl/pdm_cic_decimator.sv
// rtl/pdm_cic_decimator.sv - single-clock CIC decimator, 1-bit PDM to PCM
//
// Purpose: N-stage Hogenauer CIC, decimation ratio 2**R_LOG2, differential
//          delay 1. Integrators run every clock; the comb section and the
//          output register advance only on the decimation strobe.
// Ports:
//   clk      system clock at the PDM bit rate
//   rst      synchronous, active-high reset; clears all state
//   x_in     PDM bit, treated as unsigned 0/1
//   y_out    decimated unsigned sample, 0..R**N_STAGES
//   y_valid  one-cycle pulse coincident with each new y_out
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter  int N_STAGES = CIC_N_STAGES,
  parameter  int R_LOG2   = CIC_R_LOG2,
  localparam int OUT_W    = cic_out_w(N_STAGES, R_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  output logic [OUT_W-1:0] y_out,
  output logic             y_valid
);

  logic             strobe;
  logic [OUT_W-1:0] integ  [N_STAGES];
  logic [OUT_W-1:0] comb_c [N_STAGES+1];

  decim_strobe_gen #(
    .R_LOG2(R_LOG2)
  ) u_strobe (
    .clk   (clk),
    .rst   (rst),
    .strobe(strobe)
  );

  // Integrator chain. Each stage adds the registered value of the previous
  // stage, so the chain is pipelined. Modulo wrap is deliberate.
  for (genvar k = 0; k < N_STAGES; k++) begin : gen_integ
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] addend;

    if (k == 0) begin : gen_first
      assign addend = {{(OUT_W-1){1'b0}}, x_in};
    end else begin : gen_rest
      assign addend = integ[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        acc <= '0;
      end else begin
        acc <= acc + addend;
      end
    end

    assign integ[k] = acc;
  end

  // Comb chain: combinational modulo subtracts against the delay registers,
  // which capture each stage input only on the strobe.
  assign comb_c[0] = integ[N_STAGES-1];

  for (genvar k = 0; k < N_STAGES; k++) begin : gen_comb
    logic [OUT_W-1:0] dly;

    always_ff @(posedge clk) begin
      if (rst) begin
        dly <= '0;
      end else if (strobe) begin
        dly <= comb_c[k];
      end
    end

    assign comb_c[k+1] = comb_c[k] - dly;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= strobe;
      if (strobe) begin
        y_out <= comb_c[N_STAGES];
      end
    end
  end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb/tb_pdm_cic_decimator.sv - self-checking bench for pdm_cic_decimator
module tb_pdm_cic_decimator;

  localparam int R     = 16;
  localparam int HLEN  = 4 * (R - 1) + 1;
  localparam int HMAX  = 16384;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_in = 1'b0;
  logic [16:0] y_out;
  logic        y_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference: CIC response = input convolved with four cascaded length-R
  // boxcars, delayed by the pipeline, sampled every R-th input bit.
  int h [HLEN];
  int hist [HMAX];
  int t = 0;
  logic [16:0] last_y = '0;
  int valid_sum = 0;
  int valid_cnt = 0;
  int pat [16];

  pdm_cic_decimator dut (
    .clk    (clk),
    .rst    (rst),
    .x_in   (x_in),
    .y_out  (y_out),
    .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  function automatic int model_y(input int m);
    int acc = 0;
    for (int j = 0; j < HLEN; j++) begin
      int idx = R * m - LAT - j;
      if (idx >= 1) acc += h[j] * hist[idx];
    end
    return acc;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp_v, t);
    end
  endtask

  task automatic step(input logic x);
    logic [16:0] e;
    x_in = x;
    @(posedge clk);
    #1;
    t++;
    hist[t] = int'(x);
    if (t % R == 0) begin
      e = 17'(model_y(t / R));
      check("y_valid_on_strobe", int'(y_valid), 1);
      check("y_out_sample", int'(y_out), int'(e));
      last_y = e;
      valid_sum += int'(e);
      valid_cnt++;
    end else begin
      check("y_valid_idle", int'(y_valid), 0);
      check("y_out_hold", int'(y_out), int'(last_y));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x_in = 1'b1;
    @(posedge clk);
    #1;
    check("reset_y_out", int'(y_out), 0);
    check("reset_y_valid", int'(y_valid), 0);
    rst = 1'b0;
    t = 0;
    last_y = '0;
    valid_cnt = 0;
    valid_sum = 0;
  endtask

  initial begin
    int b [HLEN];
    int tmp [HLEN];
    // Build impulse response: boxcar convolved with itself four times.
    for (int i = 0; i < HLEN; i++) h[i] = (i < R) ? 1 : 0;
    for (int s = 1; s < 4; s++) begin
      for (int i = 0; i < HLEN; i++) begin
        tmp[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) tmp[i] += h[i - k];
      end
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end
    b = h;

    // Zeros: strobe cadence and silent output.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b0);
    check("zeros_steady", int'(last_y), 0);

    // All ones: ramps to full scale.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b1);
      if (t % R == 0 && valid_cnt >= 6) check("ones_fullscale", int'(y_out), 65536);
    end

    // Density 8/16 alternating.
    do_reset();
    for (int i = 0; i < 256; i++) step(i[0] ? 1'b0 : 1'b1);
    check("alt_steady", int'(last_y), 32768);

    // Density 4/16, pattern 1000.
    do_reset();
    for (int i = 0; i < 256; i++) step((i % 4 == 0) ? 1'b1 : 1'b0);
    check("quarter_steady", int'(last_y), 16384);

    // Single 1 after long zeros: total area equals R**N / R.
    do_reset();
    for (int i = 0; i < 160; i++) step(1'b0);
    valid_sum = 0;
    step(1'b1);
    for (int i = 0; i < 159; i++) step(1'b0);
    check("impulse_sum", valid_sum, 4096);
    check("impulse_return", int'(last_y), 0);

    // Long all-ones run: integrators wrap many times.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      step(1'b1);
      if (t % R == 0 && valid_cnt >= 6) check("wrap_fullscale", int'(y_out), 65536);
    end

    // One-cycle reset mid-stream, then resettle.
    do_reset();
    for (int i = 0; i < 160; i++) begin
      step(1'b1);
      if (t == R) check("post_reset_first_valid", int'(y_valid), 1);
    end
    check("resettle_fullscale", int'(last_y), 65536);

    // Fully random bits.
    do_reset();
    for (int i = 0; i < 2000; i++) step(1'($urandom));

    // Random repeating density patterns.
    for (int p = 0; p < 4; p++) begin
      int d = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) pat[i] = (i < d) ? 1 : 0;
      for (int i = 0; i < 16; i++) begin
        int k = $urandom_range(0, 15);
        int sw = pat[i];
        pat[i] = pat[k];
        pat[k] = sw;
      end
      do_reset();
      for (int i = 0; i < 160; i++) step(pat[i % 16] != 0);
      check("density_steady", int'(last_y), d * 4096);
    end

    if (b[0] != 1) check("impulse_table", b[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
